// File: rtl/multi_scoreboard.sv
// Tracks one value pushed into one of several FIFO channels and checks it at the arbitrated output.
// Optional SB_OCC_CHECK_EN: channel overflow/underflow also sets the sticky failure flag.
module multi_scoreboard #(
  parameter int NUM_REQS = 2,
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int SELW     = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [SELW-1:0]           sel,
  input  logic [NUM_REQS-1:0]       push,
  input  logic [NUM_REQS-1:0]       pop,
  input  logic [NUM_REQS*WIDTH-1:0] flat_data_in,
  input  logic [WIDTH-1:0]          data_out,
  output logic                      tracking,
  output logic                      data_out_vld,
  output logic                      prop_signal
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] OCC_MAX = CW'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     occ_q [NUM_REQS];
  logic [CW-1:0]     occ_d [NUM_REQS];
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  magic_q, magic_d;
  logic [SELW-1:0]   chan_q, chan_d;
  logic              fail_q, fail_d;
  logic              vld_q, vld_d;

  logic              sel_ok;
  logic              sel_push;
  logic              sel_pop;
  logic [CW-1:0]     sel_occ;
  logic [WIDTH-1:0]  sel_data;
  logic              chan_pop;
  logic              mismatch;

  // Per-channel occupancy, saturating at 0 and DEPTH.
  always_comb begin
    for (int i = 0; i < NUM_REQS; i++) begin
      occ_d[i] = occ_q[i];
      if (push[i] && !pop[i]) begin
        if (occ_q[i] != OCC_MAX) begin
          occ_d[i] = occ_q[i] + CW'(1);
        end else begin
          occ_d[i] = occ_q[i];
        end
      end else if (pop[i] && !push[i]) begin
        if (occ_q[i] != '0) begin
          occ_d[i] = occ_q[i] - CW'(1);
        end else begin
          occ_d[i] = occ_q[i];
        end
      end else begin
        occ_d[i] = occ_q[i];
      end
    end
  end

  // Mux out the selected channel's strobes, occupancy and data, and the tracked channel's pop.
  always_comb begin
    sel_ok   = 1'b0;
    sel_push = 1'b0;
    sel_pop  = 1'b0;
    sel_occ  = '0;
    sel_data = '0;
    chan_pop = 1'b0;
    for (int i = 0; i < NUM_REQS; i++) begin
      sel_ok   = sel_ok   | (sel == SELW'(i));
      sel_push = sel_push | (push[i] & (sel == SELW'(i)));
      sel_pop  = sel_pop  | (pop[i]  & (sel == SELW'(i)));
      sel_occ  = sel_occ  | ({CW{sel == SELW'(i)}} & occ_q[i]);
      sel_data = sel_data | ({WIDTH{sel == SELW'(i)}} & flat_data_in[i*WIDTH +: WIDTH]);
      chan_pop = chan_pop | (pop[i]  & (chan_q == SELW'(i)));
    end
  end

  // Tracking FSM: capture, count down entries ahead of the magic value, compare once.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    magic_d  = magic_q;
    chan_d   = chan_q;
    vld_d    = 1'b0;
    mismatch = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && sel_ok && sel_push) begin
          state_d = ST_TRACK;
          magic_d = sel_data;
          chan_d  = sel;
          // A same-cycle pop removes one entry that was ahead of the new value.
          cnt_d   = sel_occ - CW'(sel_pop && (sel_occ != '0));
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_TRACK: begin
        if (chan_pop) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
          end else begin
            state_d  = ST_DONE;
            vld_d    = 1'b1;
            mismatch = (data_out != magic_q);
          end
        end else begin
          state_d = ST_TRACK;
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

`ifdef SB_OCC_CHECK_EN
  logic occ_err;

  // Overflow (full, push, no pop) or underflow (pop while empty) on any channel.
  always_comb begin
    occ_err = 1'b0;
    for (int i = 0; i < NUM_REQS; i++) begin
      occ_err = occ_err
              | (push[i] & ~pop[i] & (occ_q[i] == OCC_MAX))
              | (pop[i] & (occ_q[i] == '0));
    end
  end

  // Sticky failure flag.
  always_comb begin
    fail_d = fail_q | mismatch | occ_err;
  end
`else
  // Sticky failure flag.
  always_comb begin
    fail_d = fail_q | mismatch;
  end
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      magic_q <= '0;
      chan_q  <= '0;
      fail_q  <= 1'b0;
      vld_q   <= 1'b0;
      for (int i = 0; i < NUM_REQS; i++) begin
        occ_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      magic_q <= magic_d;
      chan_q  <= chan_d;
      fail_q  <= fail_d;
      vld_q   <= vld_d;
      for (int i = 0; i < NUM_REQS; i++) begin
        occ_q[i] <= occ_d[i];
      end
    end
  end

  assign tracking     = (state_q == ST_TRACK);
  assign data_out_vld = vld_q;
  assign prop_signal  = ~fail_q;

endmodule

// File: tb/tb_multi_scoreboard.sv
// Directed bench for multi_scoreboard (NUM_REQS=2, WIDTH=8, DEPTH=4) against a queue-based reference model.
module tb_multi_scoreboard;

  logic       clk;
  logic       rst;
  logic       start;
  logic [0:0] sel;
  logic [1:0] push;
  logic [1:0] pop;
  logic [7:0] d0, d1, dout;
  logic       tracking, data_out_vld, prop_signal;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  multi_scoreboard #(.NUM_REQS(2), .WIDTH(8), .DEPTH(4), .SELW(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .sel          (sel),
    .push         (push),
    .pop          (pop),
    .flat_data_in ({d1, d0}),
    .data_out     (dout),
    .tracking     (tracking),
    .data_out_vld (data_out_vld),
    .prop_signal  (prop_signal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: each channel is a queue of entries, one of which may be tagged as the tracked value.
  bit       mq [2][$];
  bit       m_track, m_done, m_fail, m_vld, m_hit, m_cap;
  bit [7:0] m_magic;

  always @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < 2; c++) mq[c].delete();
      m_track = 1'b0;
      m_done  = 1'b0;
      m_fail  = 1'b0;
      m_vld   = 1'b0;
    end else begin
      m_hit = 1'b0;
      for (int c = 0; c < 2; c++) begin
        if (pop[c]) begin
          if (mq[c].size() > 0) begin
            if (mq[c].pop_front()) begin
              m_hit = 1'b1;
              if (dout != m_magic) m_fail = 1'b1;
            end
          end else begin
`ifdef SB_OCC_CHECK_EN
            m_fail = 1'b1;
`endif
          end
        end
        if (push[c]) begin
          m_cap = !m_track && !m_done && start && (int'(sel) == c);
          if (mq[c].size() < 4) begin
            mq[c].push_back(m_cap);
          end else begin
`ifdef SB_OCC_CHECK_EN
            m_fail = 1'b1;
`endif
          end
          if (m_cap) begin
            m_track = 1'b1;
            m_magic = (c == 0) ? d0 : d1;
          end
        end
      end
      if (m_hit) begin
        m_track = 1'b0;
        m_done  = 1'b1;
      end
      m_vld = m_hit;
    end
  end

  task automatic check(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_tracking", tracking, m_track);
      check("model_vld", data_out_vld, m_vld);
      check("model_prop", prop_signal, !m_fail);
    end
  end

  task automatic step(input logic s, input logic sl, input logic [1:0] pu, input logic [1:0] po,
                      input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] od);
    start = s; sel = sl; push = pu; pop = po; d0 = a0; d1 = a1; dout = od;
    @(posedge clk); #1;
    start = 1'b0; push = 2'b00; pop = 2'b00;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sel = 1'b0; push = 2'b00; pop = 2'b00;
    d0 = 8'h00; d1 = 8'h00; dout = 8'h00;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("reset_tracking", tracking, 1'b0);
    check("reset_vld", data_out_vld, 1'b0);
    check("reset_prop", prop_signal, 1'b1);

    // Single entry on ch1, matching pop.
    step(1'b1, 1'b1, 2'b10, 2'b00, 8'h00, 8'hA5, 8'h00);
    check("t30_tracking", tracking, 1'b1);
    step(1'b0, 1'b0, 2'b00, 2'b10, 8'h00, 8'h00, 8'hA5);
    check("t30_vld", data_out_vld, 1'b1);
    check("t30_done_not_tracking", tracking, 1'b0);
    idle();
    check("t30_vld_one_cycle", data_out_vld, 1'b0);
    check("t30_prop", prop_signal, 1'b1);
    step(1'b1, 1'b0, 2'b01, 2'b00, 8'h77, 8'h00, 8'h00);
    check("t30_done_ignores_start", tracking, 1'b0);

    // Two entries ahead on ch0, extra push behind the magic, ordered pops.
    do_reset();
    step(1'b0, 1'b0, 2'b01, 2'b00, 8'h11, 8'h00, 8'h00);
    step(1'b0, 1'b0, 2'b01, 2'b00, 8'h22, 8'h00, 8'h00);
    step(1'b1, 1'b0, 2'b01, 2'b00, 8'h3C, 8'h00, 8'h00);
    step(1'b0, 1'b0, 2'b00, 2'b01, 8'h00, 8'h00, 8'h11);
    check("t31_vld_after_first_pop", data_out_vld, 1'b0);
    step(1'b0, 1'b1, 2'b01, 2'b00, 8'h99, 8'h00, 8'h00);
    step(1'b0, 1'b0, 2'b00, 2'b01, 8'h00, 8'h00, 8'h22);
    check("t31_still_tracking", tracking, 1'b1);
    step(1'b0, 1'b0, 2'b00, 2'b01, 8'h00, 8'h00, 8'h3C);
    check("t31_vld", data_out_vld, 1'b1);
    check("t31_prop", prop_signal, 1'b1);

    // Mismatch sets the sticky failure until reset.
    do_reset();
    step(1'b1, 1'b1, 2'b10, 2'b00, 8'h00, 8'hA5, 8'h00);
    step(1'b0, 1'b0, 2'b00, 2'b10, 8'h00, 8'h00, 8'hA4);
    check("t32_vld", data_out_vld, 1'b1);
    check("t32_prop_low", prop_signal, 1'b0);
    idle();
    idle();
    check("t32_prop_sticky", prop_signal, 1'b0);
    do_reset();
    check("t32_prop_after_rst", prop_signal, 1'b1);

    // Capture with same-cycle pop; other channel pops never count.
    step(1'b0, 1'b0, 2'b11, 2'b00, 8'h55, 8'h66, 8'h00);
    step(1'b0, 1'b1, 2'b10, 2'b00, 8'h00, 8'h67, 8'h00);
    step(1'b1, 1'b0, 2'b01, 2'b01, 8'h77, 8'h00, 8'h55);
    step(1'b0, 1'b1, 2'b00, 2'b10, 8'h00, 8'h00, 8'h66);
    step(1'b0, 1'b0, 2'b00, 2'b10, 8'h00, 8'h00, 8'h67);
    check("t33_other_pops_ignored", tracking, 1'b1);
    step(1'b0, 1'b0, 2'b00, 2'b01, 8'h00, 8'h00, 8'h77);
    check("t33_vld", data_out_vld, 1'b1);
    check("t33_prop", prop_signal, 1'b1);

    // Reset abandons tracking, then a fresh capture works.
    do_reset();
    step(1'b0, 1'b0, 2'b01, 2'b00, 8'h01, 8'h00, 8'h00);
    step(1'b0, 1'b0, 2'b01, 2'b00, 8'h02, 8'h00, 8'h00);
    step(1'b1, 1'b0, 2'b01, 2'b00, 8'h03, 8'h00, 8'h00);
    check("t34_tracking", tracking, 1'b1);
    do_reset();
    check("t34_rst_tracking", tracking, 1'b0);
    idle();
    check("t34_no_vld", data_out_vld, 1'b0);
    step(1'b1, 1'b1, 2'b10, 2'b00, 8'h00, 8'h5A, 8'h00);
    step(1'b0, 1'b0, 2'b00, 2'b10, 8'h00, 8'h00, 8'h5A);
    check("t34_vld", data_out_vld, 1'b1);

    // Overflow on ch1, then underflow on ch0.
    do_reset();
    for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 2'b10, 2'b00, 8'h00, 8'(k), 8'h00);
`ifdef SB_OCC_CHECK_EN
    check("t35_overflow_prop", prop_signal, 1'b0);
`else
    check("t35_overflow_prop", prop_signal, 1'b1);
`endif
    do_reset();
    step(1'b0, 1'b0, 2'b00, 2'b01, 8'h00, 8'h00, 8'h00);
`ifdef SB_OCC_CHECK_EN
    check("t35_underflow_prop", prop_signal, 1'b0);
`else
    check("t35_underflow_prop", prop_signal, 1'b1);
`endif
    idle();

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
